// File: rtl/pdm_pkg.sv
// Shared constants, FSM state type and width helper for the PDM microphone front end.
package pdm_pkg;

    localparam int CLK_DIV_DEFAULT = 25;
    localparam int DECIM_DEFAULT   = 64;
    localparam int THRESH_DEFAULT  = 32;
    localparam int WARMUP_DEFAULT  = 1024;

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_RUN    = 1'b1
    } pdm_state_e;

    // A window of DECIM bits can count 0..DECIM ones, hence DECIM+1 codes.
    function automatic int sample_width(input int decim);
        return $clog2(decim + 1);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider: toggles pdm_clk every CLK_DIV system clocks and flags
// the system-clock cycle in which each rising or falling toggle takes effect.
module pdm_clk_gen #(
    parameter int CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    output logic pdm_clk,
    output logic rise,
    output logic fall
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;

    assign terminal = (div_cnt == DIV_LAST);
    // Strobes mark the cycle whose closing edge changes pdm_clk.
    assign rise     = terminal && !pdm_clk;
    assign fall     = terminal && pdm_clk;

    // Divider counter and pdm_clk register.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pdm_clk <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            pdm_clk <= ~pdm_clk;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

endmodule

// File: rtl/pdm_mic_receiver.sv
// PDM microphone receiver: clock generation, 2-FF input synchroniser, boxcar decimation
// and valid/ready sample port. Define PDM_STEREO_EN to add the right-channel accumulator.
module pdm_mic_receiver
    import pdm_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int DECIM    = DECIM_DEFAULT,
    parameter int SAMPLE_W = sample_width(DECIM),
    parameter int THRESH   = THRESH_DEFAULT,
    parameter int WARMUP   = WARMUP_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic                pdm_clk,
    input  logic                pdm_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic [SAMPLE_W-1:0] sample_r,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun,
    output logic                pdm_level,
    output logic                warm
);

    localparam int                  BIT_W    = $clog2(DECIM);
    localparam int                  WU_W     = $clog2(WARMUP + 1);
    localparam logic [BIT_W-1:0]    BIT_LAST = BIT_W'(DECIM - 1);
    localparam logic [BIT_W-1:0]    BIT_ONE  = BIT_W'(1);
    localparam logic [WU_W-1:0]     WU_LAST  = WU_W'(WARMUP - 1);
    localparam logic [WU_W-1:0]     WU_ONE   = WU_W'(1);
    localparam logic [SAMPLE_W-1:0] THRESH_V = SAMPLE_W'(THRESH);

    logic                rise;
    logic                fall;
    logic [1:0]          sync;
    logic                d_s;
    logic [SAMPLE_W-1:0] d_ext;
    logic [SAMPLE_W-1:0] acc;
    logic [SAMPLE_W-1:0] acc_next;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WU_W-1:0]     wu_cnt;
    logic                window_done;
    pdm_state_e          state;

    pdm_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .pdm_clk (pdm_clk),
        .rise    (rise),
        .fall    (fall)
    );

    // Two-stage synchroniser for the asynchronous mic bitstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], pdm_data};
        end
    end

    assign d_s         = sync[1];
    assign d_ext       = {{(SAMPLE_W - 1){1'b0}}, d_s};
    assign acc_next    = acc + d_ext;
    assign window_done = (state == ST_RUN) && rise && (bit_cnt == BIT_LAST);

    // Warm-up/run FSM, left accumulator and the sample handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_WARMUP;
            wu_cnt       <= '0;
            acc          <= '0;
            bit_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            pdm_level    <= 1'b0;
            warm         <= 1'b0;
        end else begin
            if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            case (state)
                ST_WARMUP: begin
                    if (rise) begin
                        if (wu_cnt == WU_LAST) begin
                            state <= ST_RUN;
                            warm  <= 1'b1;
                        end else begin
                            wu_cnt <= wu_cnt + WU_ONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (window_done) begin
                        // A new sample wins over a same-cycle clear from the handshake.
                        sample       <= acc_next;
                        pdm_level    <= (acc_next >= THRESH_V);
                        sample_valid <= 1'b1;
                        acc          <= '0;
                        bit_cnt      <= '0;
                        if (sample_valid && !sample_ready) begin
                            overrun <= 1'b1;
                        end
                    end else if (rise) begin
                        acc     <= acc_next;
                        bit_cnt <= bit_cnt + BIT_ONE;
                    end
                end
                default: begin
                    state <= ST_WARMUP;
                end
            endcase
        end
    end

`ifdef PDM_STEREO_EN
    logic [SAMPLE_W-1:0] acc_right;

    // Right channel is captured on pdm_clk falls and published with the left sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_right <= '0;
            sample_r  <= '0;
        end else if (window_done) begin
            sample_r  <= acc_right;
            acc_right <= '0;
        end else if ((state == ST_RUN) && fall) begin
            acc_right <= acc_right + d_ext;
        end
    end
`else
    logic unused_fall;

    assign unused_fall = fall;
    assign sample_r    = '0;
`endif

endmodule

// File: tb/tb_pdm_mic_receiver.sv
// Scoreboard bench for pdm_mic_receiver: a mic model drives random/patterned bits, a
// window-level reference model queues expected samples, and a monitor checks the port.
module tb_pdm_mic_receiver;

    localparam int CLK_DIV  = 4;
    localparam int DECIM    = 64;
    localparam int SAMPLE_W = 7;
    localparam int THRESH   = 32;
    localparam int WARMUP   = 4;
    localparam int WIN      = 2 * CLK_DIV * DECIM;
    localparam int WU_CYC   = 2 * CLK_DIV * WARMUP;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                pdm_clk;
    logic                pdm_data = 1'b1;
    logic [SAMPLE_W-1:0] sample;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;
    logic                pdm_level;
    logic                warm;

    always #5 clk = ~clk;

    pdm_mic_receiver #(
        .CLK_DIV  (CLK_DIV),
        .DECIM    (DECIM),
        .SAMPLE_W (SAMPLE_W),
        .THRESH   (THRESH),
        .WARMUP   (WARMUP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pdm_clk      (pdm_clk),
        .pdm_data     (pdm_data),
        .sample       (sample),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .pdm_level    (pdm_level),
        .warm         (warm)
    );

    typedef struct {
        int left;
        int right;
    } exp_t;

    exp_t exp_mem [256];
    int   wr_idx = 0;
    int   rd_idx = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;

    int   rises = 0, nbits = 0, acc = 0, acc_r = 0, since = 0;
    int   data_mode = 1, dens = 50, ready_mode = 0;
    logic prev_clk = 1'b0, warm_exp = 1'b0, exp_overrun = 1'b0;
    logic last_level = 1'b0, hit_ready = 1'b0, alt_bit = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One system-clock step of the mic model and the window-level reference model.
    task automatic step();
        int b;
        cyc++;
        since++;
        if (pdm_clk !== prev_clk) begin
            prev_clk = pdm_clk;
            check("pdm_clk_half_period", since, CLK_DIV);
            since = 0;
            if (pdm_clk) begin
                b = int'(pdm_data);
                rises++;
                if (!warm_exp) begin
                    if (rises == WARMUP) warm_exp = 1'b1;
                end else begin
                    acc += b;
                    nbits++;
                    if (nbits == DECIM) begin
                        if (wr_idx > rd_idx) exp_overrun = 1'b1;
                        exp_mem[wr_idx % 256] = '{acc, acc_r};
                        last_level = (acc >= THRESH);
                        wr_idx++;
                        acc   = 0;
                        acc_r = 0;
                        nbits = 0;
                    end
                end
`ifdef PDM_STEREO_EN
                case (data_mode)
                    3:       pdm_data = ($urandom_range(0, 99) < dens);
                    4:       pdm_data = 1'b0;
                    5:       pdm_data = 1'b1;
                    default: pdm_data = pdm_data;
                endcase
`endif
            end else begin
`ifdef PDM_STEREO_EN
                if (warm_exp) acc_r += int'(pdm_data);
`endif
                case (data_mode)
                    0:       pdm_data = 1'b0;
                    1:       pdm_data = 1'b1;
                    2:       begin alt_bit = ~alt_bit; pdm_data = alt_bit; end
                    3:       pdm_data = ($urandom_range(0, 99) < dens);
                    4:       pdm_data = 1'b1;
                    5:       pdm_data = 1'b0;
                    default: pdm_data = 1'b0;
                endcase
            end
        end
        hit_ready = !pdm_clk && (since == CLK_DIV - 1) && warm_exp && (nbits == DECIM - 1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b1;
        rises       = 0;
        nbits       = 0;
        acc         = 0;
        acc_r       = 0;
        since       = 0;
        warm_exp    = 1'b0;
        exp_overrun = 1'b0;
        last_level  = 1'b0;
        prev_clk    = 1'b0;
        hit_ready   = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
        check("rst_pdm_clk", int'(pdm_clk), 0);
        check("rst_sample", int'(sample), 0);
        check("rst_sample_r", int'(sample_r), 0);
        check("rst_valid", int'(sample_valid), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_level", int'(pdm_level), 0);
        check("rst_warm", int'(warm), 0);
        rst = 1'b0;
    endtask

    // Monitor: owns sample_ready and pops the scoreboard on every accepted sample.
    initial begin : monitor
        logic exp_valid;
        exp_t e;
        sample_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rd_idx       = wr_idx;
                sample_ready = 1'b0;
            end else begin
                exp_valid = (wr_idx > rd_idx);
                check("sample_valid", int'(sample_valid), int'(exp_valid));
                check("overrun", int'(overrun), int'(exp_overrun));
                check("warm", int'(warm), int'(warm_exp));
                check("pdm_level", int'(pdm_level), int'(last_level));
                case (ready_mode)
                    0:       sample_ready = 1'b1;
                    1:       sample_ready = 1'b0;
                    2:       sample_ready = ($urandom_range(0, 3) == 0);
                    3:       sample_ready = hit_ready;
                    default: sample_ready = 1'b0;
                endcase
                if (exp_valid && sample_ready) begin
                    e = exp_mem[(wr_idx - 1) % 256];
                    check("sample", int'(sample), e.left);
                    check("sample_r", int'(sample_r), e.right);
                    rd_idx = wr_idx;
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        ready_mode = 0;
        data_mode  = 1;
        do_reset(3);
        run(WU_CYC + 2 * WIN + 16);
        check("all_ones_sample", int'(sample), 64);
        check("all_ones_level", int'(pdm_level), 1);

        data_mode = 0;
        run(2 * WIN + WIN / 2);
        check("all_zeros_sample", int'(sample), 0);
        check("all_zeros_level", int'(pdm_level), 0);

        data_mode = 2;
        run(3 * WIN);
        check("alternating_sample", int'(sample), 32);
        check("alternating_level", int'(pdm_level), 1);

        data_mode  = 3;
        dens       = 50;
        ready_mode = 3;
        run(3 * WIN);
        check("ready_on_completion_overrun", int'(overrun), 0);

        ready_mode = 1;
        run(2 * WIN + WIN / 2);
        check("overrun_set", int'(overrun), 1);

        ready_mode = 0;
        data_mode  = 1;
        guard      = 0;
        while (!(warm_exp && nbits == 30) && guard < 2 * WIN) begin
            run(1);
            guard++;
        end
        check("midwindow_reached", nbits, 30);
        do_reset(3);
        run(WU_CYC + WIN + 16);
        check("post_reset_sample", int'(sample), 64);
        check("post_reset_overrun", int'(overrun), 0);

        ready_mode = 2;
        for (int k = 0; k < 6; k++) begin
            dens = int'($urandom_range(0, 100));
            run(WIN);
        end

`ifdef PDM_STEREO_EN
        ready_mode = 0;
        data_mode  = 4;
        run(3 * WIN);
        check("stereo_left_sample", int'(sample), 64);
        check("stereo_left_sample_r", int'(sample_r), 0);
        data_mode = 5;
        run(3 * WIN);
        check("stereo_right_sample", int'(sample), 0);
        check("stereo_right_sample_r", int'(sample_r), 64);
`endif

        run(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdm_mic_receiver.md
Name: pdm_mic_receiver

Overview:
- Front end for the MEMS microphone.
- Generates the PDM mic clock, synchronises and captures the 1-bit PDM stream, and decimates it by boxcar ones-counting into PCM samples.
- Drives a thresholded `pdm_level` bit, which the downstream message printer consumes as its `pdm_signal` input, plus a valid/ready sample port for logging.

Parameters:
- CLK_DIV, 25, system clocks per pdm_clk half-period; must be ≥ 4. With a 50 MHz clk this gives a 1 MHz pdm_clk.
- DECIM, 64, PDM bits accumulated per output sample; power of two, 16..256.
- SAMPLE_W, 7, sample width; must equal clog2(DECIM+1).
- THRESH, 32, `pdm_level` = 1 when sample ≥ THRESH.
- WARMUP, 1024, pdm_clk periods ignored after reset (mic start-up time).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pdm_clk  out  1  clock to microphone
- pdm_data  in  1  asynchronous PDM bitstream from microphone
- sample  out  SAMPLE_W  decimated sample (left/mono)
- sample_r  out  SAMPLE_W  right-channel sample; tied 0 unless PDM_STEREO_EN
- sample_valid  out  1  sample held valid
- sample_ready  in  1  consumer accepts sample
- overrun  out  1  sticky: a sample was overwritten before acceptance
- pdm_level  out  1  sample ≥ THRESH, registered
- warm  out  1  warm-up complete

Behaviour:
- **Reset values:** all outputs reset to 0, including `pdm_clk`. The divider, accumulator(s), bit counter, warm-up counter and synchroniser are all cleared. State goes to WARMUP.
- **Clock generation:**
  - The divider counts 0..CLK_DIV-1. On terminal count it toggles `pdm_clk`.
  - Toggle 0→1 asserts one-cycle strobe `rise`; toggle 1→0 asserts `fall`.
  - `rise` and `fall` are never asserted in the same cycle.
- **Data synchronisation:** `pdm_data` passes through a 2-FF synchroniser before use, giving a bit `d_s`.
- **Mono capture:** `d_s` is captured in the cycle `rise` is asserted. This is half a pdm_clk period after the mic drives data on the falling edge, so it is stable despite the 2-cycle synchroniser delay.
- **State WARMUP:**
  - The counter increments on each `rise`.
  - When it reaches WARMUP-1 on a `rise`, state goes to RUN and `warm` is set.
  - No accumulation occurs in WARMUP.
- **State RUN:**
  - On `rise`: `acc <= acc + d_s` and `bitcnt <= bitcnt + 1`.
  - When `bitcnt == DECIM-1` on a `rise`:
    - `sample <= acc + d_s` (full range 0..DECIM, no saturation).
    - `acc <= 0`, `bitcnt <= 0`.
    - `sample_valid <= 1`.
    - `pdm_level <= (acc + d_s ≥ THRESH)`.
  - The window is continuous: no bits are dropped between samples.
- **Handshake:**
  - `sample_valid` stays high until a cycle with `sample_ready` = 1, then clears the next cycle.
  - Simultaneous ready and new-sample completion: the new sample loads, `sample_valid` stays 1, and there is no overrun.
  - New sample with `valid` = 1 and `ready` = 0: the sample is overwritten and `overrun` is set, sticky until rst.
- **Reset mid-window:** the partial accumulation is discarded and WARMUP is re-entered. This requires a full WARMUP period before the next sample.
- **Latency:** the sample appears 1 clk after the `rise` that completes the window. `pdm_level` is updated in the same cycle.
- **Sample interval:** 2·CLK_DIV·DECIM clocks.

Optional Feature:
- Macro: PDM_STEREO_EN.
- **Defined:**
  - A second accumulator captures `d_s` on `fall` (right mic, SELECT high).
  - The bit counter still advances on `rise` only.
  - `sample_r` loads together with `sample` at window end. The right channel's last bit is the one captured on the preceding `fall`.
  - `sample_valid` and `overrun` are shared by both channels; `pdm_level` uses the left channel only.
- **Undefined:** no right accumulator; `sample_r` is constant 0.

Decomposition:
- **Package `pdm_pkg`:**
  - Default constants CLK_DIV, DECIM, THRESH, WARMUP.
  - State enum {WARMUP, RUN}.
  - Helper function for clog2 sample width.
- **Sub-module `pdm_clk_gen`:** divider plus `pdm_clk` register, emitting the `rise`/`fall` strobes.
- Synchroniser, accumulators, FSM and handshake stay in the top module.

Test Plan (CLK_DIV=4, DECIM=64, WARMUP=4, THRESH=32):
- **Reset:** rst held 3 cycles → all outputs 0, `pdm_clk` low; first `rise` on clk 4 after release; `warm` set after the 4th `rise`.
- **All ones:** `pdm_data` constant 1 → first `sample_valid` 512 clks after warm; sample=64, `pdm_level`=1.
- **All zeros / alternating:** constant 0 → sample=0, `pdm_level`=0. Then alternating 1,0 per pdm period → sample=32, `pdm_level`=1 (boundary).
- **Handshake and overrun:**
  - `sample_ready` held 0 across two windows → second sample overwrites and `overrun`=1.
  - Ready on the exact completion cycle → new sample latched, `overrun` unchanged.
- **Reset mid-window:** rst after 30 bits of ones → no sample for WARMUP plus 64 bits; the next sample=64, not 94 or a partial value.
- **Stereo (PDM_STEREO_EN):** mic drives 1 before `rise` and 0 before `fall` → sample=64, sample_r=0; swapped drive → sample=0, sample_r=64.
